// File: rtl/serial_deframer_pkg.sv
// Shared types and constants for the serial deframer and its output slice.
package serial_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } deframer_state_t;

  localparam logic START_LEVEL_DEFAULT = 1'b1;
  localparam logic STOP_LEVEL_DEFAULT  = 1'b0;
  localparam int   DEFRAMER_MAX_WIDTH  = 32;

endpackage

// File: rtl/deframer_out_slice.sv
// Output holding register for received words: valid/ready handshake and
// overrun detection when a new word arrives while the old one is unconsumed.
module deframer_out_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      // A load on the same edge as an accept wins: the slot is refilled.
      if (!valid_q || ready_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: start-bit detect, LSB-first shift of WIDTH data bits,
// stop-bit check, then hand-off to the output slice.
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter logic START_LEVEL = START_LEVEL_DEFAULT,
  parameter logic STOP_LEVEL  = STOP_LEVEL_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             DataIn,
  input  logic             DataEn,
  output logic [WIDTH-1:0] DataOut,
  output logic             DataValid,
  input  logic             DataReady,
  output logic             FrameErr,
  output logic             Overrun
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  deframer_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             load;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    if (DataEn) begin
      case (state_q)
        IDLE: begin
          if (DataIn == START_LEVEL) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = DataIn;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = STOP;
        end
        STOP: begin
          // No resync search on a bad stop bit: just drop back to IDLE.
          state_d = IDLE;
          if (DataIn == STOP_LEVEL) load = 1'b1;
          else                      frame_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  deframer_out_slice #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .load_i    (load),
    .word_i    (shift_q),
    .ready_i   (DataReady),
    .data_o    (DataOut),
    .valid_o   (DataValid),
    .overrun_o (Overrun)
  );

  assign FrameErr = frame_err_q;

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer (WIDTH=8, start=1, stop=0).
module tb_serial_deframer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       DataIn = 1'b0;
  logic       DataEn = 1'b0;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       DataReady = 1'b0;
  logic       FrameErr;
  logic       Overrun;

  int checks = 0;
  int errors = 0;

  serial_deframer #(
    .WIDTH(8),
    .START_LEVEL(1'b1),
    .STOP_LEVEL(1'b0)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .DataEn    (DataEn),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .DataReady (DataReady),
    .FrameErr  (FrameErr),
    .Overrun   (Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    DataEn = 1'b1;
    DataIn = b;
    step();
  endtask

  task automatic idle_cycle();
    DataEn = 1'b0;
    DataIn = 1'b0;
    step();
  endtask

  // Sends start, 8 data bits LSB-first, then the stop bit. Optionally raises
  // DataReady only during the stop-bit cycle.
  task automatic send_frame(input logic [7:0] w, input logic stop_bit, input logic rdy_stop);
    logic saved;
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    saved = DataReady;
    if (rdy_stop) DataReady = 1'b1;
    send_bit(stop_bit);
    DataReady = saved;
    DataEn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL reset_dataout: got %h expected 00", DataOut); end
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", DataValid); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_frameerr: got %b expected 0", FrameErr); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", Overrun); end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    DataReady = 1'b1;
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", DataValid); end
    send_bit(1'b0);
    DataEn = 1'b1;
    DataIn = 1'b0;
    checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", DataValid); end
    checks++; if (DataOut !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", DataOut); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL basic_frameerr: got %b expected 0", FrameErr); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", Overrun); end
    step();
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", DataValid); end
    idle_cycle();
  endtask

  task automatic test_frame_err();
    DataReady = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if (FrameErr !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b expected 1", FrameErr); end
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", DataValid); end
    idle_cycle();
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL ferr_one_cycle: got %b expected 0", FrameErr); end
    send_frame(8'h5A, 1'b0, 1'b0);
    checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL ferr_next_valid: got %b expected 1", DataValid); end
    checks++; if (DataOut !== 8'h5A) begin errors++; $display("FAIL ferr_next_data: got %h expected 5a", DataOut); end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_overrun();
    DataReady = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++; if (DataOut !== 8'h3C) begin errors++; $display("FAIL ovr_first_data: got %h expected 3c", DataOut); end
    send_frame(8'hC3, 1'b0, 1'b0);
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", Overrun); end
    checks++; if (DataOut !== 8'h3C) begin errors++; $display("FAIL ovr_data_held: got %h expected 3c", DataOut); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL ovr_no_ferr: got %b expected 0", FrameErr); end
    idle_cycle();
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b expected 0", Overrun); end
    checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", DataValid); end
    DataReady = 1'b1;
    step();
    DataReady = 1'b0;
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", DataValid); end
    idle_cycle();
  endtask

  task automatic test_accept_load();
    DataReady = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL al_valid: got %b expected 1", DataValid); end
    checks++; if (DataOut !== 8'hC3) begin errors++; $display("FAIL al_data: got %h expected c3", DataOut); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL al_overrun: got %b expected 0", Overrun); end
    DataReady = 1'b1;
    step();
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL al_drain: got %b expected 0", DataValid); end
    idle_cycle();
  endtask

  task automatic test_gapped();
    logic [9:0] bits;
    bits = {1'b0, 8'h81, 1'b1};  // stop, data (LSB-first), start
    DataReady = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL gap_idle_valid: got %b expected 0", DataValid); end
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[i]);
      if (i < 9) begin
        DataEn = 1'b0;
        DataIn = ~bits[i];
        step();
        DataIn = bits[i];
        step();
      end
    end
    DataEn = 1'b0;
    checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", DataValid); end
    checks++; if (DataOut !== 8'h81) begin errors++; $display("FAIL gap_data: got %h expected 81", DataOut); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL gap_frameerr: got %b expected 0", FrameErr); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    DataReady = 1'b1;
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    DataEn = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL rmid_dataout: got %h expected 00", DataOut); end
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", DataValid); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL rmid_frameerr: got %b expected 0", FrameErr); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b expected 0", Overrun); end
    send_frame(8'hFF, 1'b0, 1'b0);
    checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid: got %b expected 1", DataValid); end
    checks++; if (DataOut !== 8'hFF) begin errors++; $display("FAIL rmid_next_data: got %h expected ff", DataOut); end
    checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL rmid_next_frameerr: got %b expected 0", FrameErr); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overrun();
    test_accept_load();
    test_gapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
Name: serial_deframer

Overview:
- Downstream consumer of the registered serial bit stream produced by the inverting D flip-flop stage.
- Detects a start bit, shifts in WIDTH data bits LSB-first and checks the stop bit.
- Presents each good word on a parallel output with a valid/ready handshake.
- Flags framing errors and output overruns as single-cycle pulses.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..32.
- START_LEVEL, 1: DataIn level that marks a start bit.
- STOP_LEVEL, 0: DataIn level required for the stop bit.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- DataIn  input  1  serial bit from the upstream flop stage.
- DataEn  input  1  bit strobe; DataIn is sampled only on cycles where DataEn=1.
- DataOut  output  WIDTH  received word, LSB = first data bit.
- DataValid  output  1  DataOut holds an unconsumed word.
- DataReady  input  1  consumer accepts DataOut this cycle.
- FrameErr  output  1  one-cycle pulse: stop bit wrong, word discarded.
- Overrun  output  1  one-cycle pulse: good word dropped because the output was occupied.

Behaviour:
- Reset (sampled at a Clock edge while Reset=1):
  - state=IDLE, bit counter=0, shift register=0.
  - DataOut=0, DataValid=0, FrameErr=0, Overrun=0.
  - Reset mid-frame abandons the partial word with no error pulse.
  - Reset takes priority over every other event in the same cycle.
- State machine IDLE / DATA / STOP; transitions occur only on DataEn=1 cycles, otherwise the state holds.
  - IDLE: DataEn & DataIn==START_LEVEL -> DATA, counter=0. Any other DataIn level is ignored and the state stays IDLE.
  - DATA: each strobe writes DataIn into shift bit [counter] and increments the counter. The strobe with counter==WIDTH-1 -> STOP.
  - STOP, DataIn==STOP_LEVEL: good word -> IDLE.
    - If DataValid==0, or DataValid & DataReady in the same cycle: load DataOut and set DataValid=1 at the next edge (the load wins over the accept).
    - Else DataOut is unchanged, DataValid stays 1 and Overrun pulses for 1 cycle.
  - STOP, DataIn!=STOP_LEVEL: FrameErr pulses for 1 cycle -> IDLE. There is no load and no resynchronisation search.
- Latency: DataValid rises on the edge that samples the stop strobe. With continuous DataEn and the start bit at cycle 0, DataValid is visible from cycle WIDTH+2.
- Handshake:
  - DataOut is stable while DataValid=1.
  - A transfer occurs on a cycle with DataValid & DataReady; DataValid drops at the next edge unless a new word loads on the same edge.
  - DataReady while DataValid=0 is ignored.
- The earliest following start bit is the strobe after the stop strobe; there is no idle gap requirement.
- Counter width is clog2(WIDTH). The counter never wraps inside DATA because the transition to STOP happens at WIDTH-1.
- FrameErr and Overrun are registered, never asserted together, and low on every other cycle.

Decomposition:
- Shared package:
  - deframer_state_t enum (IDLE, DATA, STOP).
  - START/STOP default level constants.
  - DEFRAMER_MAX_WIDTH=32.
- One natural sub-module, deframer_out_slice: WIDTH-bit output holding register plus DataValid/DataReady logic and Overrun generation. Inputs are the load request and the word; outputs are DataOut, DataValid and Overrun.
- The state machine and shift register stay in the top.

Test Plan:
- Basic word: WIDTH=8, DataReady=1, DataEn held 1; drive start=1, bits 1,0,1,0,0,1,0,1, stop=0 -> DataOut=8'hA5, DataValid=1 for exactly cycle 10, no error pulses.
- Framing error: same frame with stop=1 -> FrameErr=1 for one cycle at cycle 10, DataValid stays 0. A following good frame 8'h5A is then received correctly.
- Overrun: DataReady=0; send 8'h3C then 8'hC3 back-to-back -> DataOut stays 8'h3C, Overrun pulses once at the second stop. Raising DataReady then gives one transfer and DataValid=0.
- Simultaneous accept and load: DataReady pulsed exactly on the stop cycle of the second word -> DataValid stays 1, DataOut changes 8'h3C->8'hC3, no Overrun.
- Gapped strobes: DataEn=1 every 3rd cycle, DataIn toggling on non-strobe cycles, frame 8'h81 -> DataOut=8'h81. Idle-level bits before the start are ignored.
- Reset mid-frame: Reset=1 for 1 cycle after 4 data bits -> all outputs 0, state IDLE. The next full frame 8'hFF decodes correctly with no FrameErr.
